key_provisioner: RTL

Writer-side front end for the hardware key store. Receives a 256-bit secret key as eight 32-bit words plus one XOR checksum word over a valid/ready stream. On a checksum match it presents the assembled key with a one-cycle `key_load` strobe, which is the load interface the key store samples. It never holds the plaintext key on its output longer than the strobe cycle, and it zeroizes internal state on error, abort, timeout or request.

---
 rtl/key_provisioner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/key_provisioner.sv
// Key-store writer front end: collects NUM_WORDS key words plus an XOR checksum and strobes the key out once.
// Build option KEY_PROV_LOCK_EN: after the first successful load the block locks until reset.
module key_provisioner #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int TIMEOUT   = 255,
    localparam int KEY_W    = WORD_W * NUM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prov_start,
    input  logic              zeroize,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic [KEY_W-1:0]  secret_key,
    output logic              key_load,
    output logic              prov_busy,
    output logic              prov_done,
    output logic              prov_err
);

    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
    localparam logic [7:0]       TMO_MAX  = 8'(TIMEOUT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    logic [1:0]        state;
    logic [KEY_W-1:0]  shadow;
    logic [WORD_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        tmo;

    logic       in_session;
    logic       accept;
    logic       last_word;
    logic       tmo_hit;
    logic       sum_ok;
    logic       locked;
    logic [1:0] commit_state;

`ifdef KEY_PROV_LOCK_EN
    localparam logic [1:0] S_LOCKED = 2'd3;
    assign locked       = (state == S_LOCKED);
    assign commit_state = S_LOCKED;
`else
    assign locked       = 1'b0;
    assign commit_state = S_IDLE;
`endif

    // A restart or zeroize request closes the port for that cycle so a coincident beat is dropped.
    always_comb begin
        in_session = (state == S_COLLECT) || (state == S_CHECK);
        prov_busy  = in_session;
        wr_ready   = in_session && !prov_start && !zeroize;
        accept     = wr_valid && wr_ready;
        last_word  = (cnt == LAST_CNT);
        tmo_hit    = (tmo == TMO_MAX);
        sum_ok     = (wr_data == acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shadow     <= '0;
            acc        <= '0;
            cnt        <= '0;
            tmo        <= '0;
            secret_key <= '0;
            key_load   <= 1'b0;
            prov_done  <= 1'b0;
            prov_err   <= 1'b0;
        end else begin
            // Key and pulses live for exactly one cycle unless reloaded below.
            secret_key <= '0;
            key_load   <= 1'b0;
            prov_done  <= 1'b0;
            prov_err   <= 1'b0;

            if (zeroize) begin
                shadow <= '0;
                acc    <= '0;
                cnt    <= '0;
                tmo    <= '0;
                state  <= locked ? state : S_IDLE;
            end else if (prov_start && !locked) begin
                shadow <= '0;
                acc    <= '0;
                cnt    <= '0;
                tmo    <= '0;
                state  <= S_COLLECT;
            end else if (in_session) begin
                if (accept) begin
                    tmo <= '0;
                    if (state == S_COLLECT) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (cnt == i[CNT_W-1:0]) begin
                                shadow[i*WORD_W +: WORD_W] <= wr_data;
                            end
                        end
                        acc <= acc ^ wr_data;
                        cnt <= cnt + CNT_W'(1);
                        if (last_word) begin
                            state <= S_CHECK;
                        end
                    end else begin
                        shadow <= '0;
                        acc    <= '0;
                        cnt    <= '0;
                        if (sum_ok) begin
                            secret_key <= shadow;
                            key_load   <= 1'b1;
                            prov_done  <= 1'b1;
                            state      <= commit_state;
                        end else begin
                            prov_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end else if (tmo_hit) begin
                    prov_err <= 1'b1;
                    shadow   <= '0;
                    acc      <= '0;
                    cnt      <= '0;
                    tmo      <= '0;
                    state    <= S_IDLE;
                end else begin
                    tmo <= tmo + 8'd1;
                end
            end
        end
    end

endmodule
